// File: rtl/gate_exerciser.sv
// -----------------------------------------------------------------------------
// gate_exerciser
//   On-chip self-test driver/checker for a 2-input combinational gate (GUT).
//   A run drives the four {a,b} vectors 00,01,10,11 into the GUT, LOOPS times.
//   Each vector is held for SETTLE_CYCLES cycles. At the end of that hold, gut_y
//   is sampled and compared against TRUTH_TABLE[{a,b}]. The run reports:
//   pass/fail, a saturating mismatch count, and the first failing vector.
//
// Parameters
//   TRUTH_TABLE    expected y indexed by {a,b}; bit0 = vector 00 (NAND default)
//   SETTLE_CYCLES  cycles each vector is held before sampling (>= 1)
//   LOOPS          passes over the four vectors per run (>= 1)
//   CNT_W          width of err_count (saturating)
//
// Ports
//   clk               in   rising-edge clock
//   rst_n             in   asynchronous active-low reset
//   start             in   run request, sampled only in IDLE
//   gut_a, gut_b      out  registered GUT inputs
//   gut_y             in   GUT output, sampled synchronously
//   busy              out  high while a run is in progress
//   done              out  one-cycle pulse at end of run
//   pass              out  no mismatches in the last run; held until next start
//   err_count         out  mismatches in the last run, saturating
//   first_fail_valid  out  at least one mismatch in the last run
//   first_fail_vec    out  {a,b} of the first mismatch; 0 if none
// -----------------------------------------------------------------------------
module gate_exerciser #(
    parameter logic [3:0] TRUTH_TABLE   = 4'b0111,
    parameter int          SETTLE_CYCLES = 1,
    parameter int          LOOPS         = 1,
    parameter int          CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             gut_a,
    output logic             gut_b,
    input  logic             gut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [1:0]       first_fail_vec
);

    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int LOOP_W = $clog2(LOOPS + 1);

    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'(LOOPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_vec;
    logic [SET_W-1:0]  r_settle;
    logic [LOOP_W-1:0] r_loop;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [CNT_W-1:0]  r_err;
    logic              r_ffv;
    logic [1:0]        r_ffvec;

    logic              w_sample;
    logic              w_mismatch;
    logic              w_last;
    logic [CNT_W-1:0]  w_err_next;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        w_sample   = 1'b0;
        w_mismatch = 1'b0;
        w_last     = 1'b0;
        w_err_next = r_err;
        if (r_state == ST_RUN && r_settle == SETTLE_LAST) begin
            w_sample   = 1'b1;
            w_mismatch = (gut_y != TRUTH_TABLE[r_vec]);
            w_last     = (r_vec == 2'b11) && (r_loop == LOOP_LAST);
        end
        // Saturate instead of wrapping so a long failing run never reads as clean.
        if (w_mismatch && r_err != {CNT_W{1'b1}}) begin
            w_err_next = r_err + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_vec    <= 2'b00;
            r_settle <= '0;
            r_loop   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_ffv    <= 1'b0;
            r_ffvec  <= 2'b00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_vec    <= 2'b00;
                        r_settle <= '0;
                        r_loop   <= '0;
                        r_busy   <= 1'b1;
                        r_pass   <= 1'b0;
                        r_err    <= '0;
                        r_ffv    <= 1'b0;
                        r_ffvec  <= 2'b00;
                    end
                end

                ST_RUN: begin
                    if (w_sample) begin
                        r_settle <= '0;
                        r_err    <= w_err_next;
                        if (w_mismatch && !r_ffv) begin
                            r_ffv   <= 1'b1;
                            r_ffvec <= r_vec;
                        end
                        // 11 wraps to 00, which also returns the GUT inputs
                        // to 00 once the run is over.
                        r_vec <= r_vec + 2'd1;
                        if (r_vec == 2'b11) begin
                            r_loop <= r_loop + 1'b1;
                        end
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            // Use the count including this final comparison.
                            r_pass  <= (w_err_next == '0);
                        end
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gut_a            = r_vec[1];
    assign gut_b            = r_vec[0];
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_valid = r_ffv;
    assign first_fail_vec   = r_ffvec;

endmodule
